// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: takes a 16-bit big-endian word count,
// then big-endian instruction bytes, and writes one 32-bit word per four bytes while holding the CPU.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic [31:0] count_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_hi_q    <= '0;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      hold_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_hi_q    <= cnt_hi_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_hi_d    = cnt_hi_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hold_d      = hold_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    count_w     = {16'h0000, cnt_hi_q, in_data};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CNT_HI;
          err_d      = 1'b0;
          hold_d     = 1'b1;
          addr_d     = BASE_ADDR;
          byte_idx_d = '0;
          word_d     = '0;
        end
      end
      CNT_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_hi_d = in_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (count_w == 32'd0) begin
            state_d = DONE;
            hold_d  = 1'b0;
          end else if (count_w > MAX_WORDS) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            remaining_d = count_w[15:0];
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // ~idx selects the lane MSB-first: byte0 -> [31:24] ... byte3 -> [7:0]
          word_d[{~byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wdata_d = word_d;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d      = addr_q + 32'd4;
        remaining_d = remaining_q - 16'd1;
        byte_idx_d  = '0;
        if (remaining_q == 16'd1) begin
          state_d = DONE;
          hold_d  = 1'b0;
        end else begin
          state_d = DATA;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                     (state_q == DATA)   || (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Byte-stream writer that fills the instruction memory before the single-cycle MIPS datapath runs.
- Accepts a word count followed by big-endian instruction bytes over a valid/ready byte interface.
- Assembles each group of four bytes into a 32-bit word and issues one write per word to the instruction memory write port.
- Holds the CPU (cpu_hold) until the load completes, so the PC never fetches from an unloaded memory.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written.
MAX_WORDS, 256, largest legal word count; a larger count is an error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  32  instruction memory byte address (word aligned)
mem_wdata  output  32  instruction word to write
cpu_hold  output  1  1 = PC/datapath must stall
busy  output  1  load in progress
done  output  1  one-cycle pulse when the load completes
err  output  1  sticky; count exceeded MAX_WORDS; cleared by the next start

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (also apply if rst_n is asserted mid-load):
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0.
  - Byte index, partial word and remaining count are cleared; a partial word is discarded.
- A byte is accepted only on a cycle where in_valid=1 and in_ready=1.
- in_ready=1 only in states CNT_HI, CNT_LO and DATA.
- IDLE:
  - start=1 -> CNT_HI. Set busy=1, err=0, cpu_hold=1, mem_addr=BASE_ADDR, byte index=0.
- CNT_HI: on accept, count[15:8]=byte -> CNT_LO.
- CNT_LO: on accept, count[7:0]=byte. Then:
  - count==0 -> DONE.
  - count>MAX_WORDS -> IDLE with err=1, busy=0, cpu_hold=1, and no writes.
  - otherwise remaining=count -> DATA.
- DATA:
  - Accepted bytes fill the word MSB first: byte0->[31:24], byte1->[23:16], byte2->[15:8], byte3->[7:0].
  - On accepting byte3 -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=current address, mem_wdata=assembled word, in_ready=0.
  - On leaving WRITE: mem_addr+=4 (wraps modulo 2^32) and remaining-=1.
  - remaining becomes 0 -> DONE; otherwise -> DATA with byte index=0.
- DONE (one cycle): done=1, busy=0, cpu_hold=0 -> IDLE.
- cpu_hold stays 0 until the next accepted start.
- Latency:
  - mem_we asserts on the cycle after the 4th byte of a word is accepted.
  - done asserts on the cycle after the last WRITE.
- Throughput: at most 1 byte per cycle, plus one bubble cycle (WRITE) per word.
- Gaps on in_valid stall the loader in its current state with no side effects.
- mem_wdata holds its last written value outside WRITE.
- mem_we never asserts outside WRITE.
- start while busy=1 is ignored (no restart, no state change).
- Simultaneous start and rst_n low: reset wins.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then release -> in_ready=0, mem_we=0, mem_addr=0, cpu_hold=1, busy=0, done=0, err=0.
- Basic two-word load:
  - Stimulus: start, then bytes 00 02 20 08 00 05 01 09 50 20, in_valid held high.
  - Required: exactly two mem_we pulses, (addr 0x0, data 0x20080005) then (addr 0x4, data 0x01095020).
  - Required: one cycle after the second write, done pulses and cpu_hold drops to 0.
- Same stream with in_valid deasserted for 3 cycles between every byte -> identical writes and data, no extra mem_we, in_ready never drops in DATA.
- Zero count: start, then bytes 00 00 -> done pulse, no mem_we, cpu_hold=0.
- Over-limit count: start, then bytes 01 01 (257 > 256) -> err=1, busy=0, cpu_hold=1, no mem_we. A following start with a valid load clears err.
- Mid-load reset and restart:
  - Stimulus: start, 00 01 AA BB, then rst_n pulse.
  - Required: reset values, no write issued.
  - Stimulus: new load 00 01 12 34 56 78.
  - Required: single write addr 0x0, data 0x12345678.
